// File: rtl/mcpu_mem_boot_arb.sv
// mcpu_mem_boot_arb: merges preloader and core client requests onto the LTC port, routes responses back
// Ports:
//   clkrst_mem_clk/rst  memory clock, synchronous active-high reset
//   pre2arb_*           preloader request (strict priority), stall and rvalid back
//   cli2arb_*           core client request, stall, rvalid and read data back
//   arb2ltc_*           registered LTC request, plus sticky protocol error flag
//   ltc2arb_*           LTC stall, in-order response valid and data
module mcpu_mem_boot_arb #(
  parameter int OUTSTANDING = 4
) (
  input  logic         clkrst_mem_clk,
  input  logic         clkrst_mem_rst,
  input  logic         pre2arb_valid,
  input  logic [2:0]   pre2arb_opcode,
  input  logic [26:0]  pre2arb_addr,
  input  logic [255:0] pre2arb_wdata,
  input  logic [31:0]  pre2arb_wbe,
  output logic         pre2arb_stall,
  output logic         pre2arb_rvalid,
  input  logic         cli2arb_valid,
  input  logic [2:0]   cli2arb_opcode,
  input  logic [26:0]  cli2arb_addr,
  input  logic [255:0] cli2arb_wdata,
  input  logic [31:0]  cli2arb_wbe,
  output logic         cli2arb_stall,
  output logic         cli2arb_rvalid,
  output logic [255:0] cli2arb_rdata,
  output logic         arb2ltc_valid,
  output logic [2:0]   arb2ltc_opcode,
  output logic [26:0]  arb2ltc_addr,
  output logic [255:0] arb2ltc_wdata,
  output logic [31:0]  arb2ltc_wbe,
  input  logic         ltc2arb_stall,
  input  logic         ltc2arb_rvalid,
  input  logic [255:0] ltc2arb_rdata,
  output logic         arb2ltc_err
);
  localparam int PW = $clog2(OUTSTANDING);
  logic [PW:0]            count;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [OUTSTANDING-1:0] tags;
  logic                   load_ok, full, pre_xfer, cli_xfer, xfer, pop;
  assign load_ok        = !arb2ltc_valid || !ltc2arb_stall;
  // full uses the pre-edge count: a same-cycle pop never frees a slot early
  assign full           = count == (PW+1)'(OUTSTANDING);
  assign pre2arb_stall  = !load_ok || full;
  assign cli2arb_stall  = !load_ok || full || pre2arb_valid;
  assign pre_xfer       = pre2arb_valid && !pre2arb_stall;
  assign cli_xfer       = cli2arb_valid && !cli2arb_stall;
  assign xfer           = pre_xfer || cli_xfer;
  assign pop            = ltc2arb_rvalid && count != '0;
  assign pre2arb_rvalid = pop && !tags[rd_ptr];
  assign cli2arb_rvalid = pop && tags[rd_ptr];
  assign cli2arb_rdata  = ltc2arb_rdata;
  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      arb2ltc_valid  <= 1'b0;
      arb2ltc_opcode <= '0;
      arb2ltc_addr   <= '0;
      arb2ltc_wdata  <= '0;
      arb2ltc_wbe    <= '0;
      arb2ltc_err    <= 1'b0;
      count          <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tags           <= '0;
    end else begin
      if (xfer) begin
        arb2ltc_valid  <= 1'b1;
        arb2ltc_opcode <= pre_xfer ? pre2arb_opcode : cli2arb_opcode;
        arb2ltc_addr   <= pre_xfer ? pre2arb_addr   : cli2arb_addr;
        arb2ltc_wdata  <= pre_xfer ? pre2arb_wdata  : cli2arb_wdata;
        arb2ltc_wbe    <= pre_xfer ? pre2arb_wbe    : cli2arb_wbe;
        tags[wr_ptr]   <= cli_xfer;
        wr_ptr         <= wr_ptr + 1'b1;
      end else if (load_ok) begin
        arb2ltc_valid <= 1'b0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(xfer) - (PW+1)'(pop);
      if (ltc2arb_rvalid && count == '0) arb2ltc_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mcpu_mem_boot_arb.sv
// tb_mcpu_mem_boot_arb: directed scoreboard bench for mcpu_mem_boot_arb
module tb_mcpu_mem_boot_arb;
  typedef struct {
    bit           src;
    logic [2:0]   op;
    logic [26:0]  addr;
    logic [255:0] wd;
    logic [31:0]  wbe;
  } req_t;
  logic         clk = 0, rst = 1;
  logic         pre_valid = 0, cli_valid = 0;
  logic [2:0]   pre_op = 0, cli_op = 0;
  logic [26:0]  pre_addr = 0, cli_addr = 0;
  logic [255:0] pre_wd = 0, cli_wd = 0;
  logic [31:0]  pre_wbe = 0, cli_wbe = 0;
  logic         pre_stall, pre_rv, cli_stall, cli_rv;
  logic [255:0] cli_rdata;
  logic         a_valid, a_err;
  logic [2:0]   a_op;
  logic [26:0]  a_addr;
  logic [255:0] a_wd;
  logic [31:0]  a_wbe;
  logic         ltc_stall = 0, auto_rv = 0, man_rv = 0, auto_en = 1;
  logic         ltc_rvalid;
  logic [255:0] rdata_drv = {8{32'h1234_5678}};
  assign ltc_rvalid = auto_rv | man_rv;
  int compared = 0, mismatched = 0;
  int cyc = 0, iss_cnt = 0, last_iss = 0, pre_rv_cnt = 0, cli_rv_cnt = 0;
  req_t exp_iss[$];
  bit   exp_rsp[$];
  int   due_q[$];
  req_t e;
  bit   s;
  mcpu_mem_boot_arb #(.OUTSTANDING(4)) dut (
    .clkrst_mem_clk(clk), .clkrst_mem_rst(rst),
    .pre2arb_valid(pre_valid), .pre2arb_opcode(pre_op), .pre2arb_addr(pre_addr),
    .pre2arb_wdata(pre_wd), .pre2arb_wbe(pre_wbe), .pre2arb_stall(pre_stall), .pre2arb_rvalid(pre_rv),
    .cli2arb_valid(cli_valid), .cli2arb_opcode(cli_op), .cli2arb_addr(cli_addr),
    .cli2arb_wdata(cli_wd), .cli2arb_wbe(cli_wbe), .cli2arb_stall(cli_stall), .cli2arb_rvalid(cli_rv),
    .cli2arb_rdata(cli_rdata),
    .arb2ltc_valid(a_valid), .arb2ltc_opcode(a_op), .arb2ltc_addr(a_addr),
    .arb2ltc_wdata(a_wd), .arb2ltc_wbe(a_wbe),
    .ltc2arb_stall(ltc_stall), .ltc2arb_rvalid(ltc_rvalid), .ltc2arb_rdata(rdata_drv),
    .arb2ltc_err(a_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // LTC model: answers each accepted request two cycles after it was accepted
  always @(posedge clk) begin
    #1;
    auto_rv = auto_en && due_q.size() > 0 && due_q[0] == cyc;
    if (auto_rv) void'(due_q.pop_front());
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (a_valid && !ltc_stall) begin
        iss_cnt++;
        last_iss = cyc;
        if (exp_iss.size() == 0) chk("unexpected_issue", a_addr, 27'h7ffffff);
        else begin
          e = exp_iss.pop_front();
          chk("iss_opcode", a_op, e.op);
          chk("iss_addr", a_addr, e.addr);
          chk("iss_wdata", a_wd, e.wd);
          chk("iss_wbe", a_wbe, e.wbe);
          exp_rsp.push_back(e.src);
          if (auto_en) due_q.push_back(cyc + 2);
        end
      end
      if (ltc_rvalid) begin
        if (exp_rsp.size() > 0) begin
          s = exp_rsp.pop_front();
          chk("rv_pre", pre_rv, !s);
          chk("rv_cli", cli_rv, s);
          if (s) chk("cli_rdata", cli_rdata, rdata_drv);
        end else begin
          chk("stray_pre_rv", pre_rv, 0);
          chk("stray_cli_rv", cli_rv, 0);
        end
        pre_rv_cnt += int'(pre_rv);
        cli_rv_cnt += int'(cli_rv);
      end else chk("idle_rv", {pre_rv, cli_rv}, 0);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(bit src, logic [26:0] a);
    req_t r;
    r.src = src;
    r.op = a[2:0];
    r.addr = a;
    r.wd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r.wbe = $urandom();
    if (!src) begin
      pre_valid = 1; pre_op = r.op; pre_addr = a; pre_wd = r.wd; pre_wbe = r.wbe;
    end else begin
      cli_valid = 1; cli_op = r.op; cli_addr = a; cli_wd = r.wd; cli_wbe = r.wbe;
    end
    exp_iss.push_back(r);
  endtask
  task automatic send(bit src, logic [26:0] a);
    int n = 0;
    drive(src, a);
    #1;
    while ((src ? cli_stall : pre_stall) && n < 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n == 50) chk("send_timeout", n, 0);
    step();
    if (!src) pre_valid = 0; else cli_valid = 0;
  endtask
  task automatic wait_idle(string tag);
    int n = 0;
    while ((exp_iss.size() > 0 || exp_rsp.size() > 0) && n < 200) begin
      step();
      n++;
    end
    chk(tag, n < 200, 1);
  endtask
  initial begin
    int first, p0, c0, i0;
    repeat (3) step();
    rst = 0;
    #1;
    chk("rst_valid", a_valid, 0);
    chk("rst_opcode", a_op, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_wdata", a_wd, 0);
    chk("rst_wbe", a_wbe, 0);
    chk("rst_err", a_err, 0);
    chk("rst_stalls", {pre_stall, cli_stall}, 0);
    step();
    // preloader stream, auto responses
    p0 = pre_rv_cnt; c0 = cli_rv_cnt; i0 = iss_cnt; first = 0;
    for (int i = 0; i < 64; i++) begin
      drive(0, 27'(i));
      #1;
      chk("t1_pre_stall", pre_stall, 0);
      step();
      pre_valid = 0;
      if (i == 0) first = cyc;
    end
    wait_idle("t1_drain");
    chk("t1_issues", iss_cnt - i0, 64);
    chk("t1_back_to_back", last_iss - first, 63);
    chk("t1_pre_rv_cnt", pre_rv_cnt - p0, 64);
    chk("t1_cli_rv_cnt", cli_rv_cnt - c0, 0);
    // simultaneous requests
    drive(0, 27'h10);
    drive(1, 27'h20);
    #1;
    chk("t2_pre_stall", pre_stall, 0);
    chk("t2_cli_stall", cli_stall, 1);
    step();
    pre_valid = 0;
    #1;
    chk("t2_cli_stall_next", cli_stall, 0);
    step();
    cli_valid = 0;
    wait_idle("t2_drain");
    // LTC backpressure
    ltc_stall = 1;
    send(0, 27'h33);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_valid", a_valid, 1);
      chk("t3_addr", a_addr, 27'h33);
      chk("t3_opcode", a_op, 3'd3);
      chk("t3_wdata", a_wd, exp_iss[0].wd);
      chk("t3_stalls", {pre_stall, cli_stall}, 2'b11);
      step();
    end
    i0 = iss_cnt;
    ltc_stall = 0;
    step();
    step();
    chk("t3_one_issue", iss_cnt - i0, 1);
    chk("t3_valid_drop", a_valid, 0);
    wait_idle("t3_drain");
    // outstanding limit, manual responses
    auto_en = 0;
    for (int k = 0; k < 4; k++) send(0, 27'h40 + 27'(k));
    drive(0, 27'h50);
    cli_valid = 1; cli_addr = 27'h60;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_full_stalls", {pre_stall, cli_stall}, 2'b11);
      step();
    end
    man_rv = 1;
    #1;
    chk("t4_pop_cycle_stall", pre_stall, 1);
    step();
    man_rv = 0;
    #1;
    chk("t4_slot_freed_pre", pre_stall, 0);
    chk("t4_slot_freed_cli", cli_stall, 1);
    step();
    pre_valid = 0;
    #1;
    chk("t4_refull", {pre_stall, cli_stall}, 2'b11);
    cli_valid = 0;
    step();
    man_rv = 1;
    repeat (4) step();
    man_rv = 0;
    wait_idle("t4_drain");
    // interleaved routing with back-to-back responses
    p0 = pre_rv_cnt; c0 = cli_rv_cnt;
    send(0, 27'h100);
    send(1, 27'h101);
    send(1, 27'h102);
    send(0, 27'h103);
    step();
    for (int k = 0; k < 4; k++) begin
      man_rv = 1;
      rdata_drv = {8{32'hA5A5_0000 | 32'(k)}};
      step();
    end
    man_rv = 0;
    wait_idle("t5_drain");
    chk("t5_pre_cnt", pre_rv_cnt - p0, 2);
    chk("t5_cli_cnt", cli_rv_cnt - c0, 2);
    // protocol error and reset
    #1;
    chk("t6_err_clear", a_err, 0);
    step();
    man_rv = 1;
    step();
    man_rv = 0;
    #1;
    chk("t6_err_set", a_err, 1);
    repeat (3) step();
    chk("t6_err_sticky", a_err, 1);
    rst = 1;
    step();
    rst = 0;
    #1;
    chk("t6_err_reset", a_err, 0);
    step();
    for (int k = 0; k < 3; k++) send(0, 27'h200 + 27'(k));
    step();
    rst = 1;
    exp_iss.delete();
    exp_rsp.delete();
    due_q.delete();
    step();
    rst = 0;
    #1;
    chk("t6_rst_valid", a_valid, 0);
    chk("t6_rst_addr", a_addr, 0);
    chk("t6_rst_stalls", {pre_stall, cli_stall}, 0);
    step();
    man_rv = 1;
    step();
    man_rv = 0;
    #1;
    chk("t6_count_zero_err", a_err, 1);
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/mcpu_mem_boot_arb.md
Name: mcpu_mem_boot_arb

Overview:
- Two-client arbiter directly downstream of the boot-ROM preloader.
- Merges the preloader request stream (pre) and the core memory client stream (cli) into the single request port of the LTC.
- Tracks issue order so each LTC response (rvalid) is routed back to the client that issued the request.
- Preloader has strict priority, so the boot image lands in memory before any core traffic.

Parameters:
- OUTSTANDING, 4: maximum requests issued but not yet answered by rvalid; includes the one held in the output register. Power of two, 2..16.

Ports:
- clkrst_mem_clk  in  1  memory clock.
- clkrst_mem_rst  in  1  synchronous reset, active-high.
- pre2arb_valid  in  1  preloader request valid.
- pre2arb_opcode  in  3  preloader LTC opcode.
- pre2arb_addr  in  27  preloader atom address, bits [31:5].
- pre2arb_wdata  in  256  preloader write data.
- pre2arb_wbe  in  32  preloader byte enables.
- pre2arb_stall  out  1  preloader must hold its request.
- pre2arb_rvalid  out  1  response belongs to the preloader.
- cli2arb_valid, cli2arb_opcode, cli2arb_addr, cli2arb_wdata, cli2arb_wbe  in  1/3/27/256/32  core client request, same meaning as the pre* fields.
- cli2arb_stall  out  1  core client must hold its request.
- cli2arb_rvalid  out  1  response belongs to the core client.
- cli2arb_rdata  out  256  read data, equal to ltc2arb_rdata.
- arb2ltc_valid  out  1  LTC request valid.
- arb2ltc_opcode  out  3  LTC opcode.
- arb2ltc_addr  out  27  LTC atom address.
- arb2ltc_wdata  out  256  LTC write data.
- arb2ltc_wbe  out  32  LTC byte enables.
- ltc2arb_stall  in  1  LTC cannot accept a request this cycle.
- ltc2arb_rvalid  in  1  one response, returned in issue order.
- ltc2arb_rdata  in  256  response data.
- arb2ltc_err  out  1  sticky flag: protocol error (rvalid with nothing outstanding).

Behaviour:
- Reset (sampled on a clock edge while clkrst_mem_rst=1):
  - arb2ltc_valid=0; opcode, addr, wdata and wbe all 0.
  - Tag FIFO emptied, count=0, arb2ltc_err=0.
  - Reset mid-transaction discards all outstanding tags; responses arriving afterwards with count=0 set err.
- Handshakes:
  - A client transfer occurs in a cycle where x2arb_valid=1 and x2arb_stall=0. The client holds all request fields while its stall is 1.
  - An LTC transfer occurs in a cycle where arb2ltc_valid=1 and ltc2arb_stall=0.
- Output register (one entry):
  - load_ok = !arb2ltc_valid || !ltc2arb_stall.
  - full = (count == OUTSTANDING).
- Grant, combinational:
  - pre wins if pre2arb_valid.
  - Otherwise cli wins if cli2arb_valid.
- Stalls:
  - pre2arb_stall = !load_ok || full.
  - cli2arb_stall = !load_ok || full || pre2arb_valid.
  - Stalls depend on valid only, never on the other client's stall.
- On a client transfer:
  - The output register loads the winner's fields, valid=1.
  - The winner's tag is pushed (0=pre, 1=cli).
  - Latency from client transfer to arb2ltc_valid: 1 cycle.
- If load_ok and no client transfer: arb2ltc_valid goes to 0 at the next edge.
- Count:
  - Increments on push, decrements on a pop caused by rvalid.
  - Push and pop in the same cycle leave count unchanged.
  - The full check uses the pre-edge count, so a same-cycle pop does not unblock a push (conservative).
- Response routing:
  - On ltc2arb_rvalid with count>0: assert pre2arb_rvalid or cli2arb_rvalid per the head tag (combinational, same cycle), then pop.
  - On ltc2arb_rvalid with count=0: no client rvalid, no pop, arb2ltc_err <= 1 until reset.
- Every opcode, write-through included, produces exactly one rvalid.
- cli2arb_rdata = ltc2arb_rdata at all times. The preloader gets no data.
- Tag FIFO: circular buffer of OUTSTANDING 1-bit entries; read/write pointers wrap modulo OUTSTANDING.

Test Plan:
- Preloader only, LTC never stalls, rvalid 2 cycles after each issue:
  - 64 atoms addr 0..63 appear on arb2ltc in order, one per cycle.
  - 64 pre2arb_rvalid pulses, no cli2arb_rvalid.
- Both valid on the same cycle (pre addr 0x10, cli addr 0x20):
  - pre issued first, cli2arb_stall=1 that cycle.
  - cli issued the next cycle.
  - rvalids route pre then cli.
- ltc2arb_stall held high 5 cycles with a request in the output register:
  - arb2ltc fields are constant.
  - Both client stalls are 1.
  - Exactly one LTC transfer once stall drops.
- OUTSTANDING=4, no rvalid returned:
  - after 4 issues both stalls stay 1.
  - One rvalid frees exactly one slot and the next request issues.
- Interleaved tags pre,cli,cli,pre with rvalids returned back-to-back:
  - routing matches that order.
  - cli2arb_rdata equals ltc2arb_rdata on each cli pulse (e.g. 256'hA5...).
- ltc2arb_rvalid with nothing outstanding:
  - arb2ltc_err=1 and stays 1.
  - Reset clears it to 0.
  - Reset asserted with 3 outstanding makes count=0 and arb2ltc_valid=0.
